// File: rtl/dr_phase_seq_if.sv
// Byte host bus plus the single-rail/dual-rail converter boundary of the AES phase sequencer.
// master = sequencer side, slave = host and datapath side.
interface dr_phase_seq_if #(
  parameter int NBYTES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic [8*NBYTES-1:0]   core_din;
  logic                  core_sp;
  logic                  core_done;
  logic [8*NBYTES-1:0]   core_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_data;

  modport master (
    input  in_valid, in_data, core_done, core_dout, out_ready,
    output in_ready, core_din, core_sp, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, core_done, core_dout, out_ready,
    input  in_ready, core_din, core_sp, out_valid, out_data
  );
endinterface

// File: rtl/dr_phase_seq.sv
// Phase sequencer: gathers a block from byte beats, runs one spacer/data cycle of the
// dual-rail core against its synchronized completion detector, then streams the result out.
module dr_phase_seq #(
  parameter int NBYTES      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TO_CYCLES   = 255
) (
  input  logic             C,
  input  logic             RN,
  dr_phase_seq_if.master   bus,
  output logic             busy,
  output logic             err
);
  localparam int BW = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  localparam int TW = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD, S_SPWAIT, S_EVAL, S_UNLOAD, S_RTZ, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          byte_cnt_q;
  logic [TW-1:0]          to_cnt_q;
  logic [BW-1:0]          din_q, dout_q;
  logic                   in_ready_q, sp_q, err_q, rtz_seen_q;

  logic done_s, accept, hs, last_byte, to_hit;
  logic to_clr, to_inc, err_set, capture;

  assign done_s    = sync_q[SYNC_STAGES-1];
  assign accept    = bus.in_valid & in_ready_q;
  assign hs        = bus.out_valid & bus.out_ready;
  assign last_byte = (byte_cnt_q == LAST_BYTE);
  assign to_hit    = (to_cnt_q == TO_LAST);

  assign bus.in_ready  = in_ready_q;
  assign bus.core_din  = din_q;
  assign bus.core_sp   = sp_q;
  assign bus.out_valid = (state_q == S_UNLOAD);
  assign bus.out_data  = dout_q[BW-1 -: 8];
  assign busy          = !((state_q == S_LOAD) && (byte_cnt_q == '0));
  assign err           = err_q;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    to_clr  = 1'b0;
    to_inc  = 1'b0;
    err_set = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (accept && last_byte) begin
          state_d = S_SPWAIT;
          to_clr  = 1'b1;
        end
      end
      S_SPWAIT: begin
        if (!done_s) begin
          state_d = S_EVAL;
          to_clr  = 1'b1;
        end else if (to_hit) begin
          state_d = S_ERR;
          err_set = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_EVAL: begin
        if (done_s) begin
          state_d = S_UNLOAD;
          capture = 1'b1;
          to_clr  = 1'b1;
        end else if (to_hit) begin
          state_d = S_ERR;
          err_set = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_UNLOAD: begin
        // The return-to-spacer wait runs alongside the drain and never stalls a handshake.
        if (hs && last_byte) begin
          state_d = (rtz_seen_q || !done_s) ? S_LOAD : S_RTZ;
          to_clr  = 1'b1;
        end else if (!rtz_seen_q && done_s) begin
          if (to_hit) begin
            state_d = S_ERR;
            err_set = 1'b1;
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      S_RTZ: begin
        if (!done_s) begin
          state_d = S_LOAD;
        end else if (to_hit) begin
          state_d = S_ERR;
          err_set = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: begin
        state_d = S_ERR;
        err_set = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge C) begin
    if (!RN) begin
      state_q    <= S_LOAD;
      sync_q     <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      din_q      <= '0;
      dout_q     <= '0;
      in_ready_q <= 1'b0;
      sp_q       <= 1'b0;
      err_q      <= 1'b0;
      rtz_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.core_done};
      in_ready_q <= (state_d == S_LOAD);
      sp_q       <= (state_d == S_EVAL);
      err_q      <= err_q | err_set;

      if (to_clr)      to_cnt_q <= '0;
      else if (to_inc) to_cnt_q <= to_cnt_q + TW'(1);

      if (accept) din_q <= {din_q[BW-9:0], bus.in_data};

      if (accept || hs) byte_cnt_q <= last_byte ? '0 : byte_cnt_q + CW'(1);

      if (capture) dout_q <= bus.core_dout;
      else if (hs) dout_q <= {dout_q[BW-9:0], 8'h00};

      if (capture)                               rtz_seen_q <= 1'b0;
      else if (state_q == S_UNLOAD && !done_s)   rtz_seen_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dr_phase_seq.sv
// Randomized bench for dr_phase_seq: behavioural core model (done = SP delayed) and a byte
// scoreboard predicting block contents, output order, completion handoff and timeouts.
module tb_dr_phase_seq;
  localparam int NB = 16;
  localparam int SS = 2;
  localparam int TO = 255;
  localparam int BW = 8 * NB;

  logic C = 1'b0;
  logic RN = 1'b0;
  logic busy, err;

  dr_phase_seq_if #(.NBYTES(NB)) bus ();

  dr_phase_seq #(.NBYTES(NB), .SYNC_STAGES(SS), .TO_CYCLES(TO)) dut (
    .C(C), .RN(RN), .bus(bus), .busy(busy), .err(err)
  );

  always #5 C = ~C;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core model: mode 0 done follows SP after core_dly cycles, 1 stuck high, 2 stuck low.
  int          core_mode = 0;
  int          core_dly  = 5;
  logic [63:0] sp_line   = '0;
  logic [7:0]  done_hist = '0;

  always @(posedge C) begin
    sp_line   <= {sp_line[62:0], bus.core_sp};
    done_hist <= {done_hist[6:0], bus.core_done};
  end

  assign bus.core_done = (core_mode == 1) ? 1'b1 :
                         (core_mode == 2) ? 1'b0 : sp_line[core_dly-1];
  assign bus.core_dout = bus.core_din ^ {NB{8'hA5}};

  // Output handshake driver: 0 always ready, 1 toggling, 2 random.
  int rdy_mode = 0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge C); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard state.
  logic [7:0]    blk [NB];
  logic [7:0]    exp_q [$];
  logic [BW-1:0] exp_block = '0;
  bit            ov_seen = 0;
  bit            check_next = 0;
  bit            exp_ready_after = 0;
  bit            waiting_rtz = 0;
  logic          sp_prev = 1'b0;
  logic          rdy_prev = 1'b0;

  always @(negedge C) begin
    if (check_next) begin
      check("ready_after_last", bus.in_ready, exp_ready_after);
      check_next = 0;
    end
    if (bus.in_ready && !rdy_prev && waiting_rtz) begin
      check("rtz_exit_done_low", done_hist[SS], 1'b0);
      waiting_rtz = 0;
    end
    if (bus.core_sp) check(sp_prev ? "din_held" : "din_at_sp", bus.core_din, exp_block);
    if (bus.out_valid) ov_seen = 1;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_out", bus.out_data, 8'hxx);
      end else begin
        check("out_byte", bus.out_data, exp_q.pop_front());
        if (exp_q.size() == 0) begin
          // Handoff decision at the next edge sees core_done as it was SS edges earlier.
          exp_ready_after = !done_hist[SS-1];
          waiting_rtz     = !exp_ready_after;
          check_next      = 1;
        end
      end
    end
    sp_prev  = bus.core_sp;
    rdy_prev = bus.in_ready;
  end

  task automatic tick();
    @(posedge C); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (!bus.in_ready && budget < 1000) begin
      tick();
      budget++;
    end
    if (budget >= 1000) check("accept_wait", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input bit gaps);
    for (int i = 0; i < NB; i++) exp_block = {exp_block[BW-9:0], blk[i]};
    for (int i = 0; i < NB; i++) send_byte(blk[i], gaps);
    for (int i = 0; i < NB; i++) exp_q.push_back(blk[i] ^ 8'hA5);
  endtask

  task automatic rand_block();
    for (int i = 0; i < NB; i++) blk[i] = 8'($urandom);
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      tick();
      budget++;
    end
    if (exp_q.size() != 0) check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (!bus.in_ready && budget < 1000) begin
      tick();
      budget++;
    end
    check("ready_return", bus.in_ready, 1'b1);
  endtask

  task automatic measure_err(output int n);
    n = 0;
    while (!err && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset(input int cycles);
    RN = 1'b0;
    exp_q.delete();
    check_next  = 0;
    waiting_rtz = 0;
    repeat (cycles) tick();
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_core_sp",   bus.core_sp,   1'b0);
    check("rst_core_din",  bus.core_din,  '0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  8'h00);
    check("rst_busy",      busy,          1'b0);
    check("rst_err",       err,           1'b0);
    RN = 1'b1;
    tick();
    check("post_rst_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    do_reset(3);

    // Counting pattern, ideal-ish core, full-rate drain.
    core_mode = 0; core_dly = 5; rdy_mode = 0;
    for (int i = 0; i < NB; i++) blk[i] = 8'(i);
    send_block(0);
    check("ready_drop", bus.in_ready, 1'b0);
    check("sp_low_after_last", bus.core_sp, 1'b0);
    tick();
    check("sp_rise", bus.core_sp, 1'b1);
    wait_drain();
    wait_ready();

    // Toggling out_ready, random delays and data with input gaps.
    rdy_mode = 1;
    for (int k = 0; k < 2; k++) begin
      core_dly = $urandom_range(1, 8);
      rand_block();
      send_block(1);
      wait_drain();
      wait_ready();
    end

    rdy_mode = 2;
    for (int k = 0; k < 2; k++) begin
      core_dly = $urandom_range(1, 12);
      rand_block();
      send_block(1);
      wait_drain();
      wait_ready();
    end

    // Sweep core latency across the point where done falls on the final handshake.
    rdy_mode = 0;
    for (int d = 10; d <= 17; d++) begin
      core_dly = d;
      repeat (70) tick();
      rand_block();
      send_block(0);
      wait_drain();
      wait_ready();
    end

    // Reset after 7 bytes discards the partial block.
    core_dly = 4;
    repeat (70) tick();
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 0);
    check("busy_mid_block", busy, 1'b1);
    do_reset(1);
    rand_block();
    send_block(0);
    wait_drain();
    wait_ready();

    // Completion stuck high after capture: RTZ timeout.
    core_dly = 3;
    rand_block();
    send_block(0);
    n = 0;
    while (!bus.core_sp && n < 200) begin
      tick();
      n++;
    end
    check("sp_seen", bus.core_sp, 1'b1);
    core_mode = 1;
    wait_drain();
    measure_err(n);
    check("rtz_err_latency", (n >= TO - 2 && n <= TO + 2), 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("err_sticky", err, 1'b1);
      check("err_sp_low", bus.core_sp, 1'b0);
      check("err_ready_low", bus.in_ready, 1'b0);
    end
    core_mode = 0;
    do_reset(1);

    // Completion stuck low in EVAL: eval timeout, nothing emitted.
    core_mode = 2;
    ov_seen = 0;
    rand_block();
    send_block(0);
    tick();
    check("eval_sp_high", bus.core_sp, 1'b1);
    measure_err(n);
    check("eval_err_latency", (n >= TO - 2 && n <= TO + 2), 1'b1);
    repeat (4) tick();
    check("eval_err_sp_low", bus.core_sp, 1'b0);
    check("eval_no_output", ov_seen, 1'b0);
    check("eval_err_ready_low", bus.in_ready, 1'b0);
    core_mode = 0;
    do_reset(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
